// File: rtl/mult_control.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : mult_control                                               |
// | Desc     : Mealy control FSM sequencing an 8x8 multiply built from a  |
// |            4x4 multiplier, accumulator and shifter.                   |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module mult_control (
    input  logic       clk,
    input  logic       reset_a,
    input  logic       start,
    input  logic [1:0] count,
    output logic [1:0] input_sel,
    output logic [1:0] shift_sel,
    output logic [2:0] state_out,
    output logic       done,
    output logic       clk_ena,
    output logic       sclr_n
);

    typedef enum logic [2:0] {
        IDLE      = 3'b000,
        LSB       = 3'b001,
        MID       = 3'b010,
        MSB       = 3'b011,
        CALC_DONE = 3'b100,
        ERR       = 3'b101
    } state_t;

    state_t r_state;
    state_t w_next_state;

    always_ff @(posedge clk) begin
        if (reset_a) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = IDLE;
        input_sel    = 2'b00;
        shift_sel    = 2'b00;
        done         = 1'b0;
        clk_ena      = 1'b0;
        sclr_n       = 1'b1;
        case (r_state)
            IDLE: begin
                if (start) begin
                    clk_ena      = 1'b1;
                    sclr_n       = 1'b0;
                    w_next_state = LSB;
                end else begin
                    w_next_state = IDLE;
                end
            end
            LSB: begin
                if (!start && count == 2'b00) begin
                    clk_ena      = 1'b1;
                    w_next_state = MID;
                end else begin
                    w_next_state = ERR;
                end
            end
            MID: begin
                // Cross products: A.lo*B.hi then A.hi*B.lo, both shifted by 4
                if (!start && count == 2'b01) begin
                    input_sel    = 2'b01;
                    shift_sel    = 2'b01;
                    clk_ena      = 1'b1;
                    w_next_state = MID;
                end else if (!start && count == 2'b10) begin
                    input_sel    = 2'b10;
                    shift_sel    = 2'b01;
                    clk_ena      = 1'b1;
                    w_next_state = MSB;
                end else begin
                    w_next_state = ERR;
                end
            end
            MSB: begin
                if (!start && count == 2'b11) begin
                    input_sel    = 2'b11;
                    shift_sel    = 2'b10;
                    clk_ena      = 1'b1;
                    w_next_state = CALC_DONE;
                end else begin
                    w_next_state = ERR;
                end
            end
            CALC_DONE: begin
                if (!start) begin
                    done         = 1'b1;
                    w_next_state = IDLE;
                end else begin
                    w_next_state = ERR;
                end
            end
            ERR: begin
                if (start) begin
                    clk_ena      = 1'b1;
                    sclr_n       = 1'b0;
                    w_next_state = LSB;
                end else begin
                    w_next_state = ERR;
                end
            end
            // 110/111 fall back to IDLE with default outputs
            default: w_next_state = IDLE;
        endcase
    end

    assign state_out = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mult_control.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_mult_control                                            |
// | Desc     : Directed self-checking bench for mult_control.             |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module tb_mult_control;

    logic       clk;
    logic       reset_a;
    logic       start;
    logic [1:0] count;
    logic [1:0] input_sel;
    logic [1:0] shift_sel;
    logic [2:0] state_out;
    logic       done;
    logic       clk_ena;
    logic       sclr_n;

    int r_total;
    int r_bad;

    mult_control dut (
        .clk       (clk),
        .reset_a   (reset_a),
        .start     (start),
        .count     (count),
        .input_sel (input_sel),
        .shift_sel (shift_sel),
        .state_out (state_out),
        .done      (done),
        .clk_ena   (clk_ena),
        .sclr_n    (sclr_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        r_total++;
        if (obs !== exp) begin
            r_bad++;
            $display("FAIL %s: got st=%b isel=%b ssel=%b done=%b ena=%b sclr_n=%b, want st=%b isel=%b ssel=%b done=%b ena=%b sclr_n=%b",
                     tag, obs[9:7], obs[6:5], obs[4:3], obs[2], obs[1], obs[0],
                     exp[9:7], exp[6:5], exp[4:3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Drive one cycle of inputs, check state and Mealy outputs mid-cycle, then clock.
    task automatic cyc(input string tag, input logic s, input logic [1:0] c,
                       input logic [2:0] e_st, input logic [1:0] e_isel,
                       input logic [1:0] e_ssel, input logic e_done,
                       input logic e_ena, input logic e_sclr);
        start = s;
        count = c;
        #2;
        check(tag, {state_out, input_sel, shift_sel, done, clk_ena, sclr_n},
                   {e_st, e_isel, e_ssel, e_done, e_ena, e_sclr});
        @(posedge clk);
        #1;
    endtask

    // Nominal count sequence starting from LSB, ending back in IDLE.
    task automatic run_from_lsb(input string tag);
        cyc({tag, "_lsb"},  1'b0, 2'd0, 3'b001, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
        cyc({tag, "_mid1"}, 1'b0, 2'd1, 3'b010, 2'b01, 2'b01, 1'b0, 1'b1, 1'b1);
        cyc({tag, "_mid2"}, 1'b0, 2'd2, 3'b010, 2'b10, 2'b01, 1'b0, 1'b1, 1'b1);
        cyc({tag, "_msb"},  1'b0, 2'd3, 3'b011, 2'b11, 2'b10, 1'b0, 1'b1, 1'b1);
        cyc({tag, "_done"}, 1'b0, 2'd0, 3'b100, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1);
        cyc({tag, "_idle"}, 1'b0, 2'd0, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        r_total = 0;
        r_bad   = 0;
        reset_a = 1'b1;
        start   = 1'b1;
        count   = 2'b10;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_a = 1'b0;

        // Reset state
        cyc("reset", 1'b0, 2'd3, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);

        // Nominal multiply
        cyc("nom_start", 1'b1, 2'd0, 3'b000, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        run_from_lsb("nom");

        // Bad count in LSB traps in ERR
        cyc("bad_start", 1'b1, 2'd0, 3'b000, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        cyc("bad_lsb",   1'b0, 2'd2, 3'b001, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        cyc("bad_err0",  1'b0, 2'd0, 3'b101, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        cyc("bad_err1",  1'b0, 2'd3, 3'b101, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);

        // Recovery from ERR via start
        cyc("rec_start", 1'b1, 2'd0, 3'b101, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        run_from_lsb("rec");

        // start held two cycles
        cyc("hold_s0", 1'b1, 2'd0, 3'b000, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        cyc("hold_s1", 1'b1, 2'd0, 3'b001, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        cyc("hold_err", 1'b0, 2'd0, 3'b101, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);

        // count=11 in MID is illegal
        cyc("m11_start", 1'b1, 2'd0, 3'b101, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        cyc("m11_lsb",   1'b0, 2'd0, 3'b001, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
        cyc("m11_mid",   1'b0, 2'd3, 3'b010, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        cyc("m11_err",   1'b0, 2'd0, 3'b101, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);

        // start during CALC_DONE is an error
        cyc("cd_start", 1'b1, 2'd0, 3'b101, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        cyc("cd_lsb",   1'b0, 2'd0, 3'b001, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
        cyc("cd_mid",   1'b0, 2'd2, 3'b010, 2'b10, 2'b01, 1'b0, 1'b1, 1'b1);
        cyc("cd_msb",   1'b0, 2'd3, 3'b011, 2'b11, 2'b10, 1'b0, 1'b1, 1'b1);
        cyc("cd_dn",    1'b1, 2'd0, 3'b100, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        cyc("cd_err",   1'b0, 2'd0, 3'b101, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);

        // Reset out of ERR, then reset mid-operation
        reset_a = 1'b1;
        cyc("rst_err", 1'b0, 2'd0, 3'b101, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        reset_a = 1'b0;
        cyc("mr_start", 1'b1, 2'd0, 3'b000, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        cyc("mr_lsb",   1'b0, 2'd0, 3'b001, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
        reset_a = 1'b1;
        cyc("mr_mid",   1'b0, 2'd1, 3'b010, 2'b01, 2'b01, 1'b0, 1'b1, 1'b1);
        reset_a = 1'b0;
        cyc("mr_idle",  1'b0, 2'd1, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        cyc("mr2_start", 1'b1, 2'd0, 3'b000, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        run_from_lsb("mr2");

        $display("test done: total=%0d bad=%0d", r_total, r_bad);
        $finish;
    end

endmodule
`default_nettype wire
